pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/pipe_ctrl_sat_counter.sv | 24 ++
 rtl/pipe_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline hazard/flush controller.
package pipe_ctrl_pkg;
   localparam int STAGES_DEF = 6;
   localparam int STG_IF     = 0;
   localparam int STG_WB     = STAGES_DEF - 1;
   localparam int PC_W       = 32;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;
endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && !(&cnt_q)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/bubble/flush controller with redirect, perf counters and stall watchdog.
//   state    | meaning
//   ST_RUN   | normal issue; stall/bubble follow stallreq
//   ST_FLUSH | one cycle per sampled flush_req; all stages cleared, redirect valid
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
   parameter int STAGES  = STAGES_DEF,
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [STAGES-1:0] stallreq,
   input  logic              flush_req,
   input  logic [PC_W-1:0]   flush_pc,
   input  logic              cnt_clr,
   output logic [STAGES-1:0] stall,
   output logic [STAGES-1:0] bubble,
   output logic [STAGES-1:0] flush,
   output logic              new_pc_valid,
   output logic [PC_W-1:0]   new_pc,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_count,
   output logic              hang
);
   localparam int WD_W = $clog2(TIMEOUT + 1);

   state_e            state_q;
   logic [PC_W-1:0]   new_pc_q;
   logic [WD_W-1:0]   wd_q;
   logic [WD_W-1:0]   wd_d;
   logic              hang_q;
   logic [STAGES-1:0] stall_raw;
   logic [STAGES-1:0] bubble_raw;
   logic              run_active;
   logic              stall_busy;

   // Stage i stalls when any stage at or beyond it requests a stall.
   always_comb begin
      stall_raw  = '0;
      bubble_raw = '0;
      for (int i = 0; i < STAGES; i++) begin
         stall_raw[i] = |(stallreq >> i);
      end
      for (int i = 1; i < STAGES; i++) begin
         bubble_raw[i] = stall_raw[i-1] & ~stall_raw[i];
      end
   end

   assign run_active = resetn && (state_q == ST_RUN);
   assign stall_busy = (state_q == ST_RUN) && (|stallreq);

   assign stall        = run_active ? stall_raw  : '0;
   assign bubble       = run_active ? bubble_raw : '0;
   assign flush        = {STAGES{state_q == ST_FLUSH}};
   assign new_pc_valid = (state_q == ST_FLUSH);
   assign new_pc       = new_pc_q;
   assign hang         = hang_q;

   always_comb begin
      wd_d = '0;
      if (stall_busy) begin
         wd_d = (wd_q == WD_W'(TIMEOUT)) ? wd_q : wd_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_RUN;
         new_pc_q <= '0;
         wd_q     <= '0;
         hang_q   <= 1'b0;
      end else begin
         state_q <= flush_req ? ST_FLUSH : ST_RUN;
         if (flush_req) begin
            new_pc_q <= flush_pc;
         end
         if (cnt_clr) begin
            wd_q   <= '0;
            hang_q <= 1'b0;
         end else begin
            wd_q <= wd_d;
            if (wd_d == WD_W'(TIMEOUT)) begin
               hang_q <= 1'b1;
            end
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (resetn),
      .inc_i (stall_busy),
      .clr_i (cnt_clr),
      .cnt_o (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (resetn),
      .inc_i (flush_req),
      .clr_i (cnt_clr),
      .cnt_o (flush_count)
   );
endmodule
